// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq
// Sequential signed multiplier. It uses radix-2 Booth recoding and runs one
// iteration per clock. After WIDTH iterations the full 2*WIDTH-bit two's
// complement product is loaded into HI/LO, and done pulses for one cycle.
//
// Ports
//   clk      in   1      single clock, rising edge
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      begin a multiply (only accepted from idle)
//   A        in   WIDTH  multiplicand, two's complement, latched on accept
//   B        in   WIDTH  multiplier, two's complement, latched on accept
//   HI       out  WIDTH  upper half of the last product (registered)
//   LO       out  WIDTH  lower half of the last product (registered)
//   busy     out  1      high while an operation is in flight
//   done     out  1      one-cycle pulse when HI/LO take a new result
//   counter  out  6      Booth iterations completed in this operation
// ---------------------------------------------------------------------------
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic [5:0]       counter
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic [WIDTH:0]   acc_q;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             accept;
    logic [WIDTH:0]   mcandExt;
    logic [WIDTH:0]   sum;

    // The cycle in which done is high is already IDLE. A start seen in that
    // cycle must still be ignored, so the done pulse blocks acceptance.
    assign accept = (state_q == IDLE) && start && !done_q;

    // Booth add/subtract step. The accumulator is one bit wider than the
    // operands, so negating the most negative multiplicand cannot overflow.
    always_comb begin
        mcandExt = {mcand_q[WIDTH-1], mcand_q};
        sum      = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum = acc_q + mcandExt;
            2'b10:   sum = acc_q - mcandExt;
            default: sum = acc_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. CALC leaves on the edge that completes iteration WIDTH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt_q == 6'(WIDTH - 1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath. After the last shift, {acc[WIDTH-1:0], Q} holds the product.
    // The extra accumulator bit is only a guard bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == FINISH);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q <= A;
                        q_q     <= B;
                        qm1_q   <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    acc_q <= {sum[WIDTH], sum[WIDTH:1]};
                    q_q   <= {sum[0], q_q[WIDTH-1:1]};
                    qm1_q <= q_q[0];
                    cnt_q <= cnt_q + 6'd1;
                end
                FINISH: begin
                    hi_q  <= acc_q[WIDTH-1:0];
                    lo_q  <= q_q;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign done    = done_q;
    assign counter = cnt_q;

endmodule
